// File: rtl/commit_window_sched.sv
// rtl/commit_window_sched.sv - in-order commit window over a circular scoreboard
// Optional build macro COMMIT_WINDOW_SCHED_PERF_EN adds retirement/stall performance counters.
module commit_window_sched #(
    parameter int NR_SB_ENTRIES   = 8,
    parameter int NR_COMMIT_PORTS = 4,
    parameter int TRANS_ID_W      = $clog2(NR_SB_ENTRIES)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic                                  halt_i,
    input  logic                                  issue_valid_i,
    input  logic                                  issue_is_store_i,
    output logic                                  issue_ready_o,
    output logic [TRANS_ID_W-1:0]                 issue_trans_id_o,
    input  logic                                  wb_valid_i,
    input  logic [TRANS_ID_W-1:0]                 wb_trans_id_i,
    input  logic                                  wb_ex_i,
    input  logic                                  store_commit_ready_i,
    output logic [NR_COMMIT_PORTS-1:0]            commit_valid_o,
    output logic [NR_COMMIT_PORTS*TRANS_ID_W-1:0] commit_id_o,
    input  logic [NR_COMMIT_PORTS-1:0]            commit_ack_i,
    output logic                                  ex_valid_o
`ifdef COMMIT_WINDOW_SCHED_PERF_EN
    ,
    output logic [63:0]                           retired_cnt_o,
    output logic [63:0]                           commit_stall_cnt_o
`endif
);

    localparam int CW = TRANS_ID_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(NR_SB_ENTRIES);

    typedef enum logic [1:0] {SLOT_FREE, SLOT_ISSUED, SLOT_DONE} slot_state_e;

    slot_state_e               slot_state [NR_SB_ENTRIES];
    logic [NR_SB_ENTRIES-1:0]  slot_ex;
    logic [NR_SB_ENTRIES-1:0]  slot_st;
    logic [TRANS_ID_W-1:0]     head;
    logic [TRANS_ID_W-1:0]     tail;
    logic [CW-1:0]             count;

    logic                      issue_hs;
    logic                      wb_hit;
    logic [NR_SB_ENTRIES-1:0]  retire_mask;
    logic [CW-1:0]             retire_n;
    logic [NR_COMMIT_PORTS-1:0] win_valid;

    assign issue_ready_o    = (count < FULL_CNT);
    assign issue_trans_id_o = tail;
    assign issue_hs         = issue_valid_i & issue_ready_o;
    assign wb_hit           = wb_valid_i && (slot_state[wb_trans_id_i] == SLOT_ISSUED)
                              && !(issue_hs && (wb_trans_id_i == tail));

    // A store flag on an excepting slot is neither counted nor gated by the store buffer.
    always_comb begin
        logic [TRANS_ID_W-1:0] idx;
        logic [CW-1:0]         store_cnt;
        logic                  all_done;
        logic                  ex_before;
        logic                  eff_st;
        logic                  run;
        win_valid   = '0;
        commit_id_o = '0;
        retire_mask = '0;
        retire_n    = '0;
        idx         = '0;
        store_cnt   = '0;
        all_done    = 1'b1;
        ex_before   = 1'b0;
        eff_st      = 1'b0;
        run         = 1'b1;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            idx = head + TRANS_ID_W'(k);
            commit_id_o[k*TRANS_ID_W +: TRANS_ID_W] = idx;
            eff_st    = slot_st[idx] & ~slot_ex[idx];
            all_done  = all_done & (slot_state[idx] == SLOT_DONE);
            store_cnt = store_cnt + CW'(eff_st);
            win_valid[k] = (CW'(k) < count) && all_done && !ex_before
                           && (store_cnt <= CW'(1))
                           && (!eff_st || store_commit_ready_i) && !halt_i;
            ex_before = ex_before | slot_ex[idx];
            run       = run & win_valid[k] & commit_ack_i[k];
            if (run) begin
                retire_mask[idx] = 1'b1;
                retire_n         = retire_n + CW'(1);
            end
        end
    end

    assign commit_valid_o = win_valid;
    assign ex_valid_o     = win_valid[0] & slot_ex[head];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_SB_ENTRIES; i++) slot_state[i] <= SLOT_FREE;
            slot_ex <= '0;
            slot_st <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < NR_SB_ENTRIES; i++) slot_state[i] <= SLOT_FREE;
            slot_ex <= '0;
            slot_st <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            for (int i = 0; i < NR_SB_ENTRIES; i++) begin
                if (retire_mask[i]) begin
                    slot_state[i] <= SLOT_FREE;
                    slot_ex[i]    <= 1'b0;
                    slot_st[i]    <= 1'b0;
                end
            end
            if (issue_hs) begin
                slot_state[tail] <= SLOT_ISSUED;
                slot_st[tail]    <= issue_is_store_i;
                slot_ex[tail]    <= 1'b0;
            end
            if (wb_hit) begin
                slot_state[wb_trans_id_i] <= SLOT_DONE;
                slot_ex[wb_trans_id_i]    <= wb_ex_i;
            end
            head  <= head + TRANS_ID_W'(retire_n);
            tail  <= tail + TRANS_ID_W'(issue_hs);
            count <= count + CW'(issue_hs) - retire_n;
        end
    end

`ifdef COMMIT_WINDOW_SCHED_PERF_EN
    // Counters survive flush; a flush cycle retires nothing.
    logic [CW-1:0] perf_n;
    assign perf_n = flush_i ? '0 : retire_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retired_cnt_o      <= '0;
            commit_stall_cnt_o <= '0;
        end else begin
            retired_cnt_o <= retired_cnt_o + 64'(perf_n);
            if ((count != '0) && (perf_n == '0))
                commit_stall_cnt_o <= commit_stall_cnt_o + 64'd1;
        end
    end
`endif

endmodule
